// File: rtl/mtpsa_tuple_sync.sv
// SUME<->SDNet tuple glue: SOP-qualified tuple_in VALID on the input side, and a tuple FIFO that gates output packets and holds their tuser.
// Define MTPSA_TUPLE_DIGEST_MERGE_EN to carry the digest in the FIFO; otherwise only metadata is stored and the tuser digest field is 0.
module mtpsa_tuple_sync #(
  parameter int META_WIDTH        = 40,
  parameter int DIGEST_WIDTH      = 256,
  parameter int TUPLE_FIFO_DEPTH  = 4,
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                                 clk_line,
  input  logic                                 clk_line_rst,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic                                 tuple_in_valid,
  output logic                                 sdnet_in_tlast,
  input  logic                                 sdnet_out_tvalid,
  output logic                                 sdnet_out_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]         sdnet_out_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]       sdnet_out_tkeep,
  input  logic                                 sdnet_out_tlast,
  input  logic                                 tuple_out_valid,
  input  logic [META_WIDTH-1:0]                tuple_out_meta,
  input  logic                                 digest_out_valid,
  input  logic [DIGEST_WIDTH-1:0]              digest_out_data,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                                 m_axis_tlast,
  output logic [DIGEST_WIDTH+META_WIDTH-1:0]   m_axis_tuser,
  output logic [CNT_WIDTH-1:0]                 stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]                 stat_ovf_cnt,
  output logic [$clog2(TUPLE_FIFO_DEPTH):0]    tuple_fifo_level
);

  localparam int AW = $clog2(TUPLE_FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef MTPSA_TUPLE_DIGEST_MERGE_EN
  localparam int FW = DIGEST_WIDTH + META_WIDTH;
`else
  localparam int FW = META_WIDTH;
`endif

  typedef enum logic {WAIT_TUPLE, IN_PKT} state_t;

  state_t        state;
  logic          in_sop;
  logic [FW-1:0] mem [TUPLE_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [FW-1:0] wr_data;
  logic [FW-1:0] head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          gate;
  logic          out_hs;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign tuple_in_valid = s_axis_tvalid & in_sop;
  assign sdnet_in_tlast = s_axis_tlast;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst)
      in_sop <= 1'b1;
    else if (s_axis_tvalid && s_axis_tready)
      in_sop <= s_axis_tlast;
  end

`ifdef MTPSA_TUPLE_DIGEST_MERGE_EN
  assign wr_data = {(digest_out_valid ? digest_out_data : {DIGEST_WIDTH{1'b0}}), tuple_out_meta};
`else
  logic unused_digest;
  assign unused_digest = ^{digest_out_valid, digest_out_data};
  assign wr_data = tuple_out_meta;
`endif

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(TUPLE_FIFO_DEPTH));
  assign head       = mem[rd_ptr];

  // Once a packet has started the FIFO is known non-empty, so the gate stays open until tlast.
  assign gate    = (state == IN_PKT) | ~fifo_empty;
  assign out_hs  = sdnet_out_tvalid & m_axis_tready & gate;
  assign pop     = out_hs & sdnet_out_tlast;
  assign push_ok = tuple_out_valid & (~fifo_full | pop);
  assign drop    = tuple_out_valid & fifo_full & ~pop;

  assign m_axis_tvalid    = sdnet_out_tvalid & gate;
  assign sdnet_out_tready = m_axis_tready & gate;
  assign m_axis_tdata     = sdnet_out_tdata;
  assign m_axis_tkeep     = sdnet_out_tkeep;
  assign m_axis_tlast     = sdnet_out_tlast;
  assign tuple_fifo_level = level;

`ifdef MTPSA_TUPLE_DIGEST_MERGE_EN
  assign m_axis_tuser = fifo_empty ? '0 : head;
`else
  assign m_axis_tuser = {{DIGEST_WIDTH{1'b0}}, (fifo_empty ? {META_WIDTH{1'b0}} : head)};
`endif

  // Storage carries no reset; level gates every read of it.
  always_ff @(posedge clk_line) begin
    if (push_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      state        <= WAIT_TUPLE;
      stat_pkt_cnt <= '0;
      stat_ovf_cnt <= '0;
    end else begin
      case (state)
        WAIT_TUPLE: if (out_hs && !sdnet_out_tlast) state <= IN_PKT;
        IN_PKT:     if (pop) state <= WAIT_TUPLE;
        default:    state <= WAIT_TUPLE;
      endcase
      if (pop && stat_pkt_cnt != '1)
        stat_pkt_cnt <= stat_pkt_cnt + 1'b1;
      if (drop && stat_ovf_cnt != '1)
        stat_ovf_cnt <= stat_ovf_cnt + 1'b1;
    end
  end

endmodule
